dmem_responder: RTL and testbench

- Data-memory responder (target side) for the processor's load/store port.
- Accepts one request at a time over a valid/ready channel, models a configurable access latency, and returns a response over a second valid/ready channel.
- Handles byte, half and word accesses with lane selection and load sign/zero extension.
- Storage is a word-organised internal array.

---
 rtl/dmem_pkg.sv | 64 ++++++
 rtl/dmem_lane.sv | 39 +++
 rtl/dmem_responder.sv | 164 ++++++++++++++++
 tb/tb_dmem_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // Size 2'b11 is reserved and decodes as a word everywhere below.
  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
    logic [1:0] res;
    case (size)
      SZ_BYTE: res = off;
      SZ_HALF: res = {off[1], 1'b0};
      default: res = 2'b00;
    endcase
    return res;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic res;
    case (size)
      SZ_BYTE: res = 1'b0;
      SZ_HALF: res = off[0];
      default: res = (off != 2'b00);
    endcase
    return res;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] res;
    case (size)
      SZ_BYTE: res = 4'b0001 << off;
      SZ_HALF: res = off[1] ? 4'b1100 : 4'b0011;
      default: res = 4'b1111;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] extract_load(input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        zext,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: res = {{24{~zext & b[7]}}, b};
      SZ_HALF: res = {{16{~zext & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering: write enables, replicated store data and extended load data.
// DMEM_MISALIGN_ERR_EN flags misaligned accesses instead of silently aligning them.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        zext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misaligned
);

  logic [1:0] eff_off;

`ifdef DMEM_MISALIGN_ERR_EN
  assign misaligned = is_misaligned(size, off);
  assign eff_off    = off;
`else
  assign misaligned = 1'b0;
  assign eff_off    = align_off(size, off);
`endif

  assign be    = byte_en(size, eff_off);
  assign rdata = extract_load(size, eff_off, zext, rword);

  // Replicate the right-aligned data into every lane; the byte enable picks the target.
  always_comb begin
    case (size)
      SZ_BYTE: wword = {4{wdata[7:0]}};
      SZ_HALF: wword = {2{wdata[15:0]}};
      default: wword = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with a fixed access latency.
// Define DMEM_MISALIGN_ERR_EN to report misaligned half/word accesses via resp_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        commit;

  logic          we_q, uns_q;
  logic [AW+1:0] addr_q;
  logic [1:0]    size_q;
  logic [31:0]   wdata_q;

  logic          cur_we, cur_uns;
  logic [AW+1:0] cur_addr;
  logic [1:0]    cur_size;
  logic [31:0]   cur_wdata;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rword, wword, lane_rdata;
  logic [3:0]  be;
  logic        misaligned;

  logic unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];

  // With zero wait cycles the access happens on the acceptance edge, so use live inputs.
  always_comb begin
    if (state_q == IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr[AW+1:0];
      cur_size  = req_size;
      cur_uns   = req_unsigned;
      cur_wdata = req_wdata;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_size  = size_q;
      cur_uns   = uns_q;
      cur_wdata = wdata_q;
    end
  end

  assign idx   = cur_addr[AW+1:2];
  assign rword = mem[idx];

  dmem_lane u_lane (
    .off       (cur_addr[1:0]),
    .size      (cur_size),
    .zext      (cur_uns),
    .wdata     (cur_wdata),
    .rword     (rword),
    .be        (be),
    .wword     (wword),
    .rdata     (lane_rdata),
    .misaligned(misaligned)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_CYCLES - 1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 32'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      err_d   = misaligned;
      rdata_d = (cur_we || misaligned) ? 32'd0 : lane_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr[AW+1:0];
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
      end
    end
  end

  // Array contents survive reset; a reset during WAIT returns to IDLE before commit.
  always_ff @(posedge clk) begin
    if (commit && cur_we && !misaligned) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (WAIT_CYCLES=1, DEPTH_WORDS=1024).
module tb_dmem_responder;

  localparam logic [1:0] SZB = 2'b00;
  localparam logic [1:0] SZH = 2'b01;
  localparam logic [1:0] SZW = 2'b10;
  localparam logic [1:0] SZR = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_vec  = 0;
  int n_fail = 0;
  logic [32:0] exp_q[$];

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares each response at the negedge before its handshake edge.
  always @(negedge clk) begin
    if (rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, e[31:0]);
        check("resp_err", {31'd0, resp_err}, {31'd0, e[32]});
      end
    end
  end

  // Issue one request from IDLE; when hold is set the response is left pending.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input bit hold);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    exp_q.push_back({exp_err, exp_rd});
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    // Scramble inputs after acceptance; they must not matter.
    req_we = ~we; req_addr = addr ^ 32'h4; req_size = ~size; req_unsigned = ~uns;
    req_wdata = ~wdata;
    check("lat_wait_valid", {31'd0, resp_valid}, 32'd0);
    check("lat_wait_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    check("lat_resp_valid", {31'd0, resp_valid}, 32'd1);
    if (!hold) begin
      for (int i = 0; i < 8; i++) begin
        if (!resp_valid) break;
        @(posedge clk); #1;
      end
      check("resp_drop", {31'd0, resp_valid}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Word store/load
    do_req(1'b1, 32'h10, SZW, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 32'h10, SZW, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

    // Byte store and sign/zero extension
    do_req(1'b1, 32'h10, SZW, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    do_req(1'b1, 32'h13, SZB, 1'b0, 32'hAAAA_AA80, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 32'h13, SZB, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0);
    do_req(1'b0, 32'h13, SZB, 1'b1, 32'h0, 32'h00000080, 1'b0, 1'b0);
    do_req(1'b0, 32'h10, SZW, 1'b0, 32'h0, 32'h80000000, 1'b0, 1'b0);

    // Half lanes and reserved size
    do_req(1'b1, 32'h30, SZW, 1'b0, 32'h11223344, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 32'h32, SZH, 1'b0, 32'h0, 32'h00001122, 1'b0, 1'b0);
    do_req(1'b0, 32'h30, SZH, 1'b0, 32'h0, 32'h00003344, 1'b0, 1'b0);
    do_req(1'b0, 32'h31, SZB, 1'b0, 32'h0, 32'h00000033, 1'b0, 1'b0);
    do_req(1'b1, 32'h32, SZH, 1'b0, 32'hFFFF8001, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 32'h32, SZH, 1'b0, 32'h0, 32'hFFFF8001, 1'b0, 1'b0);
    do_req(1'b0, 32'h32, SZH, 1'b1, 32'h0, 32'h00008001, 1'b0, 1'b0);
    do_req(1'b0, 32'h30, SZR, 1'b0, 32'h0, 32'h80013344, 1'b0, 1'b0);

    // Backpressure: response held, competing store ignored
    resp_ready = 1'b0;
    do_req(1'b0, 32'h10, SZW, 1'b0, 32'h0, 32'h80000000, 1'b0, 1'b1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_size = SZW;
    req_wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_rdata", resp_rdata, 32'h80000000);
      check("bp_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("hs_valid", {31'd0, resp_valid}, 32'd0);
    check("hs_rdata", resp_rdata, 32'd0);
    check("hs_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("hs_no_accept", {31'd0, req_ready}, 32'd1);
    do_req(1'b0, 32'h10, SZW, 1'b0, 32'h0, 32'h80000000, 1'b0, 1'b0);

    // Address wrap
    do_req(1'b1, 32'h1000, SZW, 1'b0, 32'h12345678, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 32'h0, SZW, 1'b0, 32'h0, 32'h12345678, 1'b0, 1'b0);
    do_req(1'b0, 32'hFFFFF000, SZW, 1'b0, 32'h0, 32'h12345678, 1'b0, 1'b0);

    // Reset during WAIT discards the store
    req_we = 1'b1; req_addr = 32'h10; req_size = SZW; req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 32'h10, SZW, 1'b0, 32'h0, 32'h80000000, 1'b0, 1'b0);

    // Misaligned half store and word load
    do_req(1'b1, 32'h20, SZW, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef DMEM_MISALIGN_ERR_EN
    do_req(1'b1, 32'h21, SZH, 1'b0, 32'h0000ABCD, 32'h0, 1'b1, 1'b0);
    do_req(1'b0, 32'h20, SZW, 1'b0, 32'h0, 32'h00000000, 1'b0, 1'b0);
    do_req(1'b0, 32'h22, SZW, 1'b0, 32'h0, 32'h00000000, 1'b1, 1'b0);
`else
    do_req(1'b1, 32'h21, SZH, 1'b0, 32'h0000ABCD, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 32'h20, SZW, 1'b0, 32'h0, 32'h0000ABCD, 1'b0, 1'b0);
    do_req(1'b0, 32'h22, SZW, 1'b0, 32'h0, 32'h0000ABCD, 1'b0, 1'b0);
`endif

    repeat (2) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
